// File: rtl/gmii_tx_framer_if.sv
// ----------------------------------------------------------------------------
// gmii_tx_framer_if
//
// Purpose: payload byte stream carried from the repeater core into the GMII
// transmit framer. It is a plain valid/ready handshake with frame delimiting
// and an error marker per byte.
//
// Signals:
//   S_DATA  [7:0] payload byte                      (master -> slave)
//   S_VALID       payload byte valid                (master -> slave)
//   S_LAST        last byte of the current frame    (master -> slave)
//   S_ERR         byte is corrupt, flag it on TXER  (master -> slave)
//   S_READY       slave accepts the byte this cycle (slave -> master)
//
// Modports:
//   master - the repeater core side that sources bytes
//   slave  - the framer side that consumes bytes
// ----------------------------------------------------------------------------
interface gmii_tx_framer_if;
  logic [7:0] S_DATA;
  logic       S_VALID;
  logic       S_LAST;
  logic       S_ERR;
  logic       S_READY;

  modport master (
    output S_DATA,
    output S_VALID,
    output S_LAST,
    output S_ERR,
    input  S_READY
  );

  modport slave (
    input  S_DATA,
    input  S_VALID,
    input  S_LAST,
    input  S_ERR,
    output S_READY
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// ----------------------------------------------------------------------------
// gmii_tx_framer
//
// Purpose: egress framer for one GMII repeater port. It pulls payload bytes
// from the repeater core and drives the PHY transmit pins. Every frame gets a
// freshly generated preamble and SFD. A minimum inter-frame gap is held
// between frames. Upstream error bytes and mid-frame underruns are flagged on
// TXER.
//
// Parameters:
//   PRE_LEN  number of 0x55 preamble bytes before the SFD (1..15)
//   IFG_LEN  minimum number of TXEN-low cycles between frames (1..255)
//
// Ports:
//   TCLK      125 MHz GMII transmit clock, rising edge
//   SRST      synchronous reset, active high
//   s_if      payload stream (slave side): S_DATA/S_VALID/S_LAST/S_ERR in,
//             S_READY out (S_READY is decoded from the state register)
//   TXD       GMII transmit data, registered
//   TXEN      GMII transmit enable, registered
//   TXER      GMII transmit error, registered
//   BUSY      high whenever the framer is not idle
//   UNDERRUN  one-cycle pulse on the cycle an aborted frame shows TXER
// ----------------------------------------------------------------------------
module gmii_tx_framer #(
  parameter int PRE_LEN = 7,
  parameter int IFG_LEN = 12
) (
  input  logic                  TCLK,
  input  logic                  SRST,
  gmii_tx_framer_if.slave       s_if,
  output logic [7:0]            TXD,
  output logic                  TXEN,
  output logic                  TXER,
  output logic                  BUSY,
  output logic                  UNDERRUN
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    DRAIN,
    IFG
  } state_t;

  // Terminal counts for the shared 8-bit counter
  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_LEN - 1);

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  logic [7:0] w_nextCnt;
  logic [7:0] r_txd;
  logic [7:0] w_nextTxd;
  logic       r_txen;
  logic       w_nextTxen;
  logic       r_txer;
  logic       w_nextTxer;
  logic       r_underrun;
  logic       w_nextUnderrun;
  logic       w_ready;

  // Next-state and next-output decode. The GMII pins are registered from the
  // values computed here, so whatever is decided on a transition appears on
  // the pins during the first cycle of the new state. That makes the first
  // preamble byte show up right after S_VALID is seen in IDLE, and each
  // accepted byte show up the cycle after its handshake. The same counter
  // times the preamble and the inter-frame gap because they never overlap.
  // Every output defaults to the idle pattern (TXD 0, TXEN/TXER low), so the
  // underrun cycle only has to raise TXEN/TXER on top of TXD = 0.
  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    w_nextTxd      = 8'h00;
    w_nextTxen     = 1'b0;
    w_nextTxer     = 1'b0;
    w_nextUnderrun = 1'b0;
    w_ready        = 1'b0;

    case (r_state)
      IDLE: begin
        if (s_if.S_VALID) begin
          w_nextState = PRE;
          w_nextCnt   = 8'd0;
          w_nextTxd   = PREAMBLE_BYTE;
          w_nextTxen  = 1'b1;
        end
      end

      PRE: begin
        w_nextTxen = 1'b1;
        if (r_cnt == PRE_LAST) begin
          w_nextState = SFD;
          w_nextCnt   = 8'd0;
          w_nextTxd   = SFD_BYTE;
        end else begin
          w_nextCnt = r_cnt + 8'd1;
          w_nextTxd = PREAMBLE_BYTE;
        end
      end

      // The SFD cycle already accepts the first payload byte, so it shares
      // the data-phase handling. A missing byte here aborts the frame.
      SFD, DATA: begin
        w_ready    = 1'b1;
        w_nextTxen = 1'b1;
        if (s_if.S_VALID) begin
          w_nextTxd   = s_if.S_DATA;
          w_nextTxer  = s_if.S_ERR;
          w_nextCnt   = 8'd0;
          w_nextState = s_if.S_LAST ? IFG : DATA;
        end else begin
          w_nextTxer     = 1'b1;
          w_nextUnderrun = 1'b1;
          w_nextState    = DRAIN;
        end
      end

      // Swallow the rest of an aborted frame so the next frame starts clean
      DRAIN: begin
        w_ready = 1'b1;
        if (s_if.S_VALID && s_if.S_LAST) begin
          w_nextState = IFG;
          w_nextCnt   = 8'd0;
        end
      end

      // Entered on the handshake of the last byte, so IFG_LEN cycles here plus
      // the one IDLE cycle give exactly IFG_LEN TXEN-low cycles back to back
      IFG: begin
        if (r_cnt == IFG_LAST) begin
          w_nextState = IDLE;
          w_nextCnt   = 8'd0;
        end else begin
          w_nextCnt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 8'd0;
      end
    endcase
  end

  // State, counter and GMII output registers. Reset drops the line straight
  // to idle, truncating any frame in flight without TXER and without an IFG.
  always_ff @(posedge TCLK) begin
    if (SRST) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_txd      <= 8'h00;
      r_txen     <= 1'b0;
      r_txer     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_txd      <= w_nextTxd;
      r_txen     <= w_nextTxen;
      r_txer     <= w_nextTxer;
      r_underrun <= w_nextUnderrun;
    end
  end

  assign s_if.S_READY = w_ready;
  assign TXD          = r_txd;
  assign TXEN         = r_txen;
  assign TXER         = r_txer;
  assign UNDERRUN     = r_underrun;
  assign BUSY         = (r_state != IDLE);

endmodule

// File: tb/tb_gmii_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_gmii_tx_framer
//
// Purpose: directed self-checking bench for gmii_tx_framer. Instance A runs
// the default parameters, instance B the minimal ones (PRE_LEN = 1,
// IFG_LEN = 1). A negedge monitor logs every TXEN-high beat of the selected
// instance, the lengths of TXEN-low gaps between frames, and any idle-value
// violation; each test compares that log with a hand-built expected beat list.
// ----------------------------------------------------------------------------
module tb_gmii_tx_framer;

  logic       TCLK;
  logic       SRST;

  logic [7:0] sData;
  logic       sValid;
  logic       sLast;
  logic       sErr;
  logic       sel;

  logic [7:0] txdA;
  logic       txenA;
  logic       txerA;
  logic       busyA;
  logic       underrunA;
  logic [7:0] txdB;
  logic       txenB;
  logic       txerB;
  logic       busyB;
  logic       underrunB;

  int compared;
  int mismatched;

  logic [9:0] txLog[$];
  logic [9:0] expQ[$];
  int         gapLog[$];
  int         lowRun;
  int         idleBad;
  logic       sawHigh;

  gmii_tx_framer_if ifA ();
  gmii_tx_framer_if ifB ();

  // Both instances see the same bytes, but only the selected one sees S_VALID
  assign ifA.S_DATA  = sData;
  assign ifA.S_LAST  = sLast;
  assign ifA.S_ERR   = sErr;
  assign ifA.S_VALID = sValid & ~sel;
  assign ifB.S_DATA  = sData;
  assign ifB.S_LAST  = sLast;
  assign ifB.S_ERR   = sErr;
  assign ifB.S_VALID = sValid & sel;

  gmii_tx_framer #(.PRE_LEN(7), .IFG_LEN(12)) dutA (
    .TCLK     (TCLK),
    .SRST     (SRST),
    .s_if     (ifA.slave),
    .TXD      (txdA),
    .TXEN     (txenA),
    .TXER     (txerA),
    .BUSY     (busyA),
    .UNDERRUN (underrunA)
  );

  gmii_tx_framer #(.PRE_LEN(1), .IFG_LEN(1)) dutB (
    .TCLK     (TCLK),
    .SRST     (SRST),
    .s_if     (ifB.slave),
    .TXD      (txdB),
    .TXEN     (txenB),
    .TXER     (txerB),
    .BUSY     (busyB),
    .UNDERRUN (underrunB)
  );

  logic [7:0] txdSel;
  logic       txenSel;
  logic       txerSel;
  logic       busySel;
  logic       undSel;
  logic       readySel;

  assign txdSel   = sel ? txdB      : txdA;
  assign txenSel  = sel ? txenB     : txenA;
  assign txerSel  = sel ? txerB     : txerA;
  assign busySel  = sel ? busyB     : busyA;
  assign undSel   = sel ? underrunB : underrunA;
  assign readySel = sel ? ifB.S_READY : ifA.S_READY;

  // 125 MHz transmit clock
  initial begin
    TCLK = 1'b0;
    forever #4 TCLK = ~TCLK;
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Negedge monitor: log each TXEN-high beat as {UNDERRUN, TXER, TXD}, record
  // the length of every TXEN-low run that sits between two frames, and count
  // idle cycles that do not show TXD = 0 with TXER and UNDERRUN low
  always @(negedge TCLK) begin
    if (txenSel) begin
      if (sawHigh && lowRun > 0) gapLog.push_back(lowRun);
      txLog.push_back({undSel, txerSel, txdSel});
      sawHigh = 1'b1;
      lowRun  = 0;
    end else begin
      lowRun = lowRun + 1;
      if (txdSel != 8'h00 || txerSel || undSel) idleBad = idleBad + 1;
    end
  end

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearLogs();
    txLog.delete();
    expQ.delete();
    gapLog.delete();
    lowRun  = 0;
    idleBad = 0;
    sawHigh = 1'b0;
  endtask

  task automatic expPreamble(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(10'h055);
    expQ.push_back(10'h0D5);
  endtask

  task automatic expByte(input logic [7:0] d, input logic err);
    expQ.push_back({1'b0, err, d});
  endtask

  // Offer one byte and hold it until the selected framer accepts it
  task automatic applyStimulus(input logic [7:0] d, input logic last, input logic err);
    int   guard;
    logic acc;
    sData  = d;
    sLast  = last;
    sErr   = err;
    sValid = 1'b1;
    acc    = 1'b0;
    guard  = 0;
    while (!acc && guard < 400) begin
      @(negedge TCLK);
      acc = readySel;
      @(posedge TCLK);
      #1;
      guard = guard + 1;
    end
    checkOutput($sformatf("accept %02h", d), 32'(acc), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int guard;
    guard = 0;
    @(negedge TCLK);
    while (busySel && guard < 400) begin
      @(negedge TCLK);
      guard = guard + 1;
    end
    checkOutput({tag, " back to idle"}, 32'(busySel), 32'd0);
    repeat (2) @(posedge TCLK);
    #1;
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, " beat count"}, 32'(txLog.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < txLog.size(); i++)
      checkOutput($sformatf("%s beat %0d", tag, i), 32'(txLog[i]), 32'(expQ[i]));
    checkOutput({tag, " idle values"}, 32'(idleBad), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    sel        = 1'b0;
    sValid     = 1'b0;
    sData      = 8'h00;
    sLast      = 1'b0;
    sErr       = 1'b0;
    SRST       = 1'b1;
    clearLogs();

    // Reset state
    repeat (3) @(posedge TCLK);
    @(negedge TCLK);
    checkOutput("reset TXD",      32'(txdA),        32'h00);
    checkOutput("reset TXEN",     32'(txenA),       32'd0);
    checkOutput("reset TXER",     32'(txerA),       32'd0);
    checkOutput("reset UNDERRUN", 32'(underrunA),   32'd0);
    checkOutput("reset S_READY",  32'(ifA.S_READY), 32'd0);
    checkOutput("reset BUSY",     32'(busyA),       32'd0);
    SRST = 1'b0;
    @(posedge TCLK);
    #1;

    // Basic frame 12 34 56 78
    $display("[TB] basic frame");
    clearLogs();
    applyStimulus(8'h12, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0);
    applyStimulus(8'h56, 1'b0, 1'b0);
    applyStimulus(8'h78, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("basic");
    expPreamble(7);
    expByte(8'h12, 1'b0);
    expByte(8'h34, 1'b0);
    expByte(8'h56, 1'b0);
    expByte(8'h78, 1'b0);
    compareLog("basic");

    // Back-to-back frames with S_VALID held high throughout
    $display("[TB] back-to-back frames");
    clearLogs();
    applyStimulus(8'h12, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0);
    applyStimulus(8'h56, 1'b0, 1'b0);
    applyStimulus(8'h78, 1'b1, 1'b0);
    applyStimulus(8'h9A, 1'b0, 1'b0);
    applyStimulus(8'hBC, 1'b0, 1'b0);
    applyStimulus(8'hDE, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("b2b");
    expPreamble(7);
    expByte(8'h12, 1'b0);
    expByte(8'h34, 1'b0);
    expByte(8'h56, 1'b0);
    expByte(8'h78, 1'b0);
    expPreamble(7);
    expByte(8'h9A, 1'b0);
    expByte(8'hBC, 1'b0);
    expByte(8'hDE, 1'b0);
    expByte(8'hF0, 1'b0);
    expByte(8'h11, 1'b0);
    expByte(8'h22, 1'b0);
    compareLog("b2b");
    checkOutput("b2b gap count", 32'(gapLog.size()), 32'd1);
    if (gapLog.size() > 0) checkOutput("b2b gap length", 32'(gapLog[0]), 32'd12);

    // Underrun after the 2nd byte; 56 78 drained, then frame 01 02 offered.
    // TXEN low = 2 drain cycles + 12 IFG cycles = 14.
    $display("[TB] underrun");
    clearLogs();
    applyStimulus(8'h12, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0);
    sValid = 1'b0;
    @(posedge TCLK);
    #1;
    applyStimulus(8'h56, 1'b0, 1'b0);
    applyStimulus(8'h78, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("underrun");
    expPreamble(7);
    expByte(8'h12, 1'b0);
    expByte(8'h34, 1'b0);
    expQ.push_back(10'h300);
    expPreamble(7);
    expByte(8'h01, 1'b0);
    expByte(8'h02, 1'b0);
    compareLog("underrun");
    checkOutput("underrun gap count", 32'(gapLog.size()), 32'd1);
    if (gapLog.size() > 0) checkOutput("underrun gap length", 32'(gapLog[0]), 32'd14);

    // Upstream error on the 3rd byte
    $display("[TB] upstream error byte");
    clearLogs();
    applyStimulus(8'h12, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0);
    applyStimulus(8'h56, 1'b0, 1'b1);
    applyStimulus(8'h78, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("err");
    expPreamble(7);
    expByte(8'h12, 1'b0);
    expByte(8'h34, 1'b0);
    expByte(8'h56, 1'b1);
    expByte(8'h78, 1'b0);
    compareLog("err");

    // Reset during the 3rd preamble byte, frame re-offered right after
    $display("[TB] reset mid-preamble");
    clearLogs();
    sData  = 8'hAA;
    sLast  = 1'b1;
    sErr   = 1'b0;
    sValid = 1'b1;
    repeat (3) @(posedge TCLK);
    #1;
    checkOutput("pre3 TXD",  32'(txdA),  32'h55);
    checkOutput("pre3 TXEN", 32'(txenA), 32'd1);
    SRST = 1'b1;
    @(posedge TCLK);
    @(negedge TCLK);
    checkOutput("srst TXEN",    32'(txenA),       32'd0);
    checkOutput("srst TXD",     32'(txdA),        32'h00);
    checkOutput("srst TXER",    32'(txerA),       32'd0);
    checkOutput("srst S_READY", 32'(ifA.S_READY), 32'd0);
    checkOutput("srst BUSY",    32'(busyA),       32'd0);
    SRST = 1'b0;
    #1;
    clearLogs();
    @(posedge TCLK);
    #1;
    checkOutput("restart TXEN", 32'(txenA), 32'd1);
    checkOutput("restart TXD",  32'(txdA),  32'h55);
    applyStimulus(8'hAA, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("restart");
    expPreamble(7);
    expByte(8'hAA, 1'b0);
    compareLog("restart");

    // Minimal parameters on instance B: A5 then 5A back to back
    $display("[TB] minimal parameters");
    sel = 1'b1;
    clearLogs();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    sValid = 1'b0;
    waitIdle("minimal");
    expPreamble(1);
    expByte(8'hA5, 1'b0);
    expPreamble(1);
    expByte(8'h5A, 1'b0);
    compareLog("minimal");
    checkOutput("minimal gap count", 32'(gapLog.size()), 32'd1);
    if (gapLog.size() > 0) checkOutput("minimal gap length", 32'(gapLog[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
